byte_add_pipe: RTL and testbench

//  Avalon-MM read-modify-write engine: reads ceil(length/BYTE_CNT) words from base_addr and

---
 rtl/byte_add_pipe.sv | 156 +++++++++++++++
 tb/tb_byte_add_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_add_pipe.sv
// byte_add_pipe: Avalon-MM read-modify-write engine.
// Reads ceil(length/BYTE_CNT) words from base_addr and adds incr to every byte.
// Each word is written back to the address it was read from, and the tail lanes are
// masked through byteenable. Reads are pipelined. The number of reads in flight plus the
// number of words buffered never exceeds MAX_OUTSTANDING.
// Build option: define BYTE_ADD_PIPE_SATURATE_EN for a saturating per-byte add.
// Without it, each byte add wraps modulo 256.
module byte_add_pipe #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int BYTE_CNT        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] length_i,
  input  logic [7:0]            incr_i,
  input  logic                  run_i,
  output logic                  waitrequest_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
  output logic                  amm_rd_read_o,
  input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
  input  logic                  amm_rd_readdatavalid_i,
  input  logic                  amm_rd_waitrequest_i,
  output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
  output logic                  amm_wr_write_o,
  output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
  output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
  input  logic                  amm_wr_waitrequest_i
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg, words_reg, issued_reg, written_reg;
  logic [7:0]            incr_reg;
  logic [BYTE_CNT-1:0]   tail_be_reg;
  logic [CNT_W-1:0]      inflight_reg, fifo_count_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];

  // Job decode from the run-time inputs: word count rounds up, tail lanes from remainder
  logic [ADDR_WIDTH:0]   len_round;
  logic [ADDR_WIDTH-1:0] words_start, len_rem;
  logic [BYTE_CNT-1:0]   tail_be_start;

  assign len_round   = {1'b0, length_i} + (ADDR_WIDTH+1)'(BYTE_CNT - 1);
  assign words_start = ADDR_WIDTH'(len_round / (ADDR_WIDTH+1)'(BYTE_CNT));
  assign len_rem     = length_i % ADDR_WIDTH'(BYTE_CNT);

  for (genvar gi = 0; gi < BYTE_CNT; gi++) begin : g_tail
    assign tail_be_start[gi] = (len_rem == '0) || (ADDR_WIDTH'(gi) < len_rem);
  end

  // Handshake qualifiers; every strobe depends on registered state only, so it stays
  // stable while the slave stalls
  logic [CNT_W:0]        credit_used;
  logic                  rd_req, rd_fire, push, wr_req, wr_fire, last_word, run_accept;
  logic [DATA_WIDTH-1:0] head, wr_data;

  assign run_accept  = (state_reg == ST_IDLE) && run_i;
  assign credit_used = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
  assign rd_req      = (state_reg == ST_RUN) && (issued_reg < words_reg) &&
                       (credit_used < (CNT_W+1)'(MAX_OUTSTANDING));
  assign rd_fire     = rd_req && !amm_rd_waitrequest_i;
  assign push        = (state_reg == ST_RUN) && amm_rd_readdatavalid_i;
  assign wr_req      = (state_reg == ST_RUN) && (fifo_count_reg != '0);
  assign wr_fire     = wr_req && !amm_wr_waitrequest_i;
  assign last_word   = (written_reg == words_reg - ADDR_WIDTH'(1));
  assign head        = fifo_mem[rd_ptr_reg];

  // Per-lane delta applied to the FIFO head
  for (genvar gi = 0; gi < BYTE_CNT; gi++) begin : g_lane
`ifdef BYTE_ADD_PIPE_SATURATE_EN
    logic [8:0] lane_sum;
    assign lane_sum = {1'b0, head[8*gi +: 8]} + {1'b0, incr_reg};
    assign wr_data[8*gi +: 8] = lane_sum[8] ? 8'hFF : lane_sum[7:0];
`else
    assign wr_data[8*gi +: 8] = head[8*gi +: 8] + incr_reg;
`endif
  end

  // Next-state logic: a zero-length job goes straight to DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (run_i) state_next = (length_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (wr_fire && last_word) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, job registers, counters and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg      <= ST_IDLE;
      base_reg       <= '0;
      words_reg      <= '0;
      incr_reg       <= '0;
      tail_be_reg    <= '0;
      issued_reg     <= '0;
      written_reg    <= '0;
      inflight_reg   <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (run_accept) begin
        base_reg    <= base_addr_i;
        words_reg   <= words_start;
        incr_reg    <= incr_i;
        tail_be_reg <= tail_be_start;
        issued_reg  <= '0;
        written_reg <= '0;
      end else begin
        if (rd_fire) issued_reg  <= issued_reg + ADDR_WIDTH'(1);
        if (wr_fire) written_reg <= written_reg + ADDR_WIDTH'(1);
      end
      case ({rd_fire, push})
        2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
        2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      case ({push, wr_fire})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (push)    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (wr_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // FIFO storage: no reset needed, the occupancy count guards its contents
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= amm_rd_readdata_i;
  end

  // Outputs are zero whenever the matching strobe is low
  assign waitrequest_o       = (state_reg != ST_IDLE);
  assign done_o              = (state_reg == ST_DONE);
  assign amm_rd_read_o       = rd_req;
  assign amm_rd_address_o    = rd_req ? base_reg + issued_reg : '0;
  assign amm_wr_write_o      = wr_req;
  assign amm_wr_address_o    = wr_req ? base_reg + written_reg : '0;
  assign amm_wr_writedata_o  = wr_req ? wr_data : '0;
  assign amm_wr_byteenable_o = wr_req ? (last_word ? tail_be_reg : '1) : '0;

endmodule

// File: tb/tb_byte_add_pipe.sv
// tb_byte_add_pipe: table-driven and randomized bench for byte_add_pipe.
// The bench models the Avalon read slave and write slave.
// Every write is scored against a word-level reference built from memory at run start.
module tb_byte_add_pipe;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BC = 4;
  localparam int MO = 4;
  localparam int NV = 15;

`ifdef BYTE_ADD_PIPE_SATURATE_EN
  localparam logic [31:0] EXP_T2 = 32'hFFFFFFFF;
`else
  localparam logic [31:0] EXP_T2 = 32'h7FFF7FFF;
`endif

  logic clk_i_tb = 1'b0;
  always #5 clk_i_tb = ~clk_i_tb;

  logic          srst, run, waitreq, done;
  logic [AW-1:0] base_addr, length, rd_addr, wr_addr;
  logic [7:0]    incr;
  logic          rd_read, rd_valid, rd_wait, wr_write, wr_wait;
  logic [DW-1:0] rd_data, wr_data;
  logic [BC-1:0] wr_be;

  byte_add_pipe dut (
    .clk_i(clk_i_tb), .srst_i(srst), .base_addr_i(base_addr), .length_i(length),
    .incr_i(incr), .run_i(run), .waitrequest_o(waitreq), .done_o(done),
    .amm_rd_address_o(rd_addr), .amm_rd_read_o(rd_read), .amm_rd_readdata_i(rd_data),
    .amm_rd_readdatavalid_i(rd_valid), .amm_rd_waitrequest_i(rd_wait),
    .amm_wr_address_o(wr_addr), .amm_wr_write_o(wr_write), .amm_wr_writedata_o(wr_data),
    .amm_wr_byteenable_o(wr_be), .amm_wr_waitrequest_i(wr_wait)
  );

  typedef struct {
    logic [9:0]  base;
    int          len;
    logic [7:0]  incr;
    bit          rd_stall;
    bit          wr_stall;
    int          lat;
    int          abort_at;
    int          exp_words;
    logic [3:0]  exp_last_be;
    logic [9:0]  exp_last_addr;
    bit          chk_data;
    logic [31:0] exp_first_data;
  } vec_t;

  typedef struct { logic [9:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  logic [31:0] mem [1024];
  wr_t  exp_q[$];
  rsp_t rsp_q[$];
  vec_t tbl [NV];

  int n_vec = 0, n_err = 0, cyc = 0;
  int reads_acc, writes_acc, done_cnt, busy_cnt, cur_lat;
  logic [9:0]  cur_base, prev_rd_addr, prev_wr_addr, last_wr_addr;
  logic [31:0] prev_wr_data, first_wr_data;
  logic [3:0]  prev_wr_be, last_wr_be;
  bit cur_rd_stall, cur_wr_stall, prev_rd_stall, prev_wr_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the byte rules
  function automatic logic [7:0] add_byte(input logic [7:0] a, input logic [7:0] d);
    int s;
    s = int'(a) + int'(d);
`ifdef BYTE_ADD_PIPE_SATURATE_EN
    if (s > 255) s = 255;
`endif
    return 8'(s % 256);
  endfunction

  function automatic int words_of(input int len);
    return (len + BC - 1) / BC;
  endfunction

  function automatic logic [3:0] last_be_of(input int len);
    int t;
    t = len - BC * (words_of(len) - 1);
    return 4'((1 << t) - 1);
  endfunction

  // One bus cycle, called at a negedge: drive slave inputs for the coming edge and score it
  task automatic bus_cycle();
    cyc++;
    rd_wait = cur_rd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
    wr_wait = cur_wr_stall && ((cyc % 4) < 2);
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      rd_valid = 1'b0;
      rd_data  = $urandom;
    end
    if (prev_rd_stall) begin
      chk("rd_hold_read", rd_read, 1);
      chk("rd_hold_addr", rd_addr, prev_rd_addr);
    end
    prev_rd_stall = 0;
    if (rd_read) begin
      if (rd_wait) begin
        prev_rd_stall = 1;
        prev_rd_addr  = rd_addr;
      end else begin
        chk("rd_addr", rd_addr, 10'(cur_base + reads_acc));
        rsp_q.push_back('{mem[rd_addr], cyc + cur_lat});
        reads_acc++;
      end
    end
    if (prev_wr_stall) begin
      chk("wr_hold_write", wr_write, 1);
      chk("wr_hold_addr", wr_addr, prev_wr_addr);
      chk("wr_hold_data", wr_data, prev_wr_data);
      chk("wr_hold_be", wr_be, prev_wr_be);
    end
    prev_wr_stall = 0;
    if (wr_write) begin
      if (wr_wait) begin
        prev_wr_stall = 1;
        prev_wr_addr  = wr_addr;
        prev_wr_data  = wr_data;
        prev_wr_be    = wr_be;
      end else begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", exp_q.size(), 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_be", wr_be, e.be);
        end
        if (writes_acc == 0) first_wr_data = wr_data;
        last_wr_addr = wr_addr;
        last_wr_be   = wr_be;
        writes_acc++;
        for (int k = 0; k < BC; k++)
          if (wr_be[k]) mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
      end
    end
    chk("credit_limit", (reads_acc - writes_acc) <= MO, 1);
    if (done) done_cnt++;
    if (waitreq) busy_cnt++;
  endtask

  task automatic do_run(input vec_t v);
    int  w;
    bit  finished, aborted;
    wr_t e;
    w = words_of(v.len);
    exp_q.delete();
    for (int i = 0; i < w; i++) begin
      e.addr = 10'(v.base + i);
      for (int k = 0; k < BC; k++) e.data[8*k +: 8] = add_byte(mem[e.addr][8*k +: 8], v.incr);
      e.be = (i == w - 1) ? last_be_of(v.len) : 4'hF;
      exp_q.push_back(e);
    end
    cur_base = v.base; cur_lat = v.lat;
    cur_rd_stall = v.rd_stall; cur_wr_stall = v.wr_stall;
    reads_acc = 0; writes_acc = 0; done_cnt = 0; busy_cnt = 0;
    prev_rd_stall = 0; prev_wr_stall = 0;
    finished = 0; aborted = 0;

    @(negedge clk_i_tb);
    chk("idle_waitreq", waitreq, 0);
    base_addr = v.base; length = 10'(v.len); incr = v.incr; run = 1'b1;
    bus_cycle();
    for (int t = 0; t < 3000 && !finished; t++) begin
      @(negedge clk_i_tb);
      // Scramble inputs mid-transfer, and poke run while busy: both must be ignored
      base_addr = $urandom; length = $urandom; incr = $urandom;
      run = waitreq ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_cycle();
      if (done) finished = 1;
      if (v.abort_at > 0 && writes_acc >= v.abort_at && !finished) begin
        srst = 1'b1;
        @(negedge clk_i_tb);
        srst = 1'b0; run = 1'b0;
        chk("abort_waitreq", waitreq, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_read", rd_read, 0);
        chk("abort_rd_addr", rd_addr, 0);
        chk("abort_wr_write", wr_write, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_wr_be", wr_be, 0);
        cur_rd_stall = 0; cur_wr_stall = 0; prev_rd_stall = 0; prev_wr_stall = 0;
        // Late read data still arrives here and must not wake the engine
        for (int k = 0; k < 12; k++) begin
          if (k > 0) @(negedge clk_i_tb);
          bus_cycle();
          chk("late_rdv_strobes", {rd_read, wr_write}, 0);
          chk("late_rdv_waitreq", waitreq, 0);
        end
        aborted = 1; finished = 1;
      end
    end
    chk("run_completes", finished, 1);
    if (aborted) begin
      $display("run base=%h len=%0d incr=%h aborted by reset after %0d writes",
               v.base, v.len, v.incr, writes_acc);
      return;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i_tb);
      run = 1'b0;
      bus_cycle();
      chk("post_waitreq", waitreq, 0);
      chk("post_strobes", {rd_read, wr_write}, 0);
    end
    chk("write_count", writes_acc, v.exp_words);
    chk("read_count", reads_acc, v.exp_words);
    chk("done_pulses", done_cnt, 1);
    if (v.exp_words > 0) begin
      chk("last_addr", last_wr_addr, v.exp_last_addr);
      chk("last_be", last_wr_be, v.exp_last_be);
    end
    if (v.chk_data) chk("first_data", first_wr_data, v.exp_first_data);
    if (v.len == 0) chk("len0_busy_cycles", busy_cnt, 1);
    $display("run base=%h len=%0d incr=%h lat=%0d writes=%0d busy=%0d done=%0d",
             v.base, v.len, v.incr, v.lat, writes_acc, busy_cnt, done_cnt);
  endtask

  initial begin
    srst = 1'b1; run = 1'b0; base_addr = '0; length = '0; incr = '0;
    rd_valid = 1'b0; rd_data = '0; rd_wait = 1'b0; wr_wait = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h010] = 32'h03020100; mem[10'h011] = 32'h07060504;
    mem[10'h012] = 32'h0B0A0908; mem[10'h013] = 32'h0F0E0D0C;
    mem[10'h040] = 32'hFF7FFF7F; mem[10'h041] = 32'h7F7FFFFF;

    //           base    len incr  rds  wrs  lat ab  wds be       last     chk  first
    tbl[0] = '{10'h010, 15, 8'h01, 1'b0, 1'b0, 1, 0, 4, 4'b0111, 10'h013, 1'b1, 32'h04030201};
    tbl[1] = '{10'h040,  6, 8'h80, 1'b0, 1'b0, 2, 0, 2, 4'b0011, 10'h041, 1'b1, EXP_T2};
    tbl[2] = '{10'h080, 32, 8'h5A, 1'b1, 1'b1, 3, 0, 8, 4'b1111, 10'h087, 1'b0, 32'h0};
    tbl[3] = '{10'h3FF,  8, 8'h03, 1'b0, 1'b0, 2, 0, 2, 4'b1111, 10'h000, 1'b0, 32'h0};
    tbl[4] = '{10'h200,  0, 8'h11, 1'b0, 1'b0, 1, 0, 0, 4'b0000, 10'h000, 1'b0, 32'h0};
    tbl[5] = '{10'h100, 32, 8'h07, 1'b0, 1'b0, 3, 2, 8, 4'b1111, 10'h107, 1'b0, 32'h0};
    tbl[6] = '{10'h100,  4, 8'h09, 1'b0, 1'b0, 1, 0, 1, 4'b1111, 10'h100, 1'b0, 32'h0};
    for (int i = 7; i < NV; i++) begin
      tbl[i].base          = 10'($urandom);
      tbl[i].len           = $urandom_range(1, 60);
      tbl[i].incr          = 8'($urandom);
      tbl[i].rd_stall      = 1'($urandom_range(0, 1));
      tbl[i].wr_stall      = 1'($urandom_range(0, 1));
      tbl[i].lat           = $urandom_range(1, 4);
      tbl[i].abort_at      = 0;
      tbl[i].exp_words     = words_of(tbl[i].len);
      tbl[i].exp_last_be   = last_be_of(tbl[i].len);
      tbl[i].exp_last_addr = 10'(tbl[i].base + tbl[i].exp_words - 1);
      tbl[i].chk_data      = 1'b0;
      tbl[i].exp_first_data = 32'h0;
    end

    repeat (3) @(negedge clk_i_tb);
    chk("rst_waitreq", waitreq, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_read", rd_read, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_write", wr_write, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_be", wr_be, 0);
    srst = 1'b0;

    for (int i = 0; i < NV; i++) do_run(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
